spi_ram: RTL

Single-port byte-wide RAM that consumes the 10-bit command words produced by the SPI slave interface and returns read bytes to it. The block decodes the 2-bit opcode in each received word, then performs one of four actions: latch a write address, write a data byte, latch a read address, or read a data byte. For a read, the block presents the byte on `dout` and holds `tx_valid` long enough for the slave to shift it out on MISO. The block sits directly downstream of the SPI slave on `rx_data`/`rx_valid` and directly upstream of it on `tx_data`/`tx_valid`.

---
 rtl/spi_ram_if.sv | 23 ++
 rtl/spi_ram.sv | 112 +++++++++++
 2 files changed

// File: rtl/spi_ram_if.sv
// Command/response bus between the SPI slave and spi_ram.
// master: the SPI slave side (issues 10-bit command words, receives read bytes).
// slave:  the RAM side (decodes command words, returns read bytes).
interface spi_ram_if;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;

    modport master (
        output din,
        output rx_valid,
        input  dout,
        input  tx_valid
    );

    modport slave (
        input  din,
        input  rx_valid,
        output dout,
        output tx_valid
    );
endinterface

// File: rtl/spi_ram.sv
// spi_ram: byte-wide single-port RAM driven by 10-bit SPI command words.
// Opcodes (din[9:8]): 00 latch write address, 01 write byte,
// 10 latch read address, 11 read byte (dout held valid for TX_HOLD cycles).
// Optional feature: define SPI_RAM_AUTO_INC_EN to post-increment wr_addr
// after each 01 and rd_addr after each 11 (wrapping modulo MEM_DEPTH).
// MEM_DEPTH must equal 2**ADDR_SIZE and ADDR_SIZE must not exceed 8.
module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int TX_HOLD   = 10
) (
    input  logic      clk,
    input  logic      rst,
    spi_ram_if.slave  bus
);

    localparam int              CNT_W     = $clog2(TX_HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(TX_HOLD - 1);

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } opcode_t;

    typedef enum logic {
        IDLE = 1'b0,
        TX   = 1'b1
    } state_t;

    logic [7:0]           mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [CNT_W-1:0]     hold_cnt;
    state_t               state;
    logic [7:0]           dout_r;
    logic                 tx_valid_r;

    opcode_t              op;
    logic [ADDR_SIZE-1:0] payload_addr;
    logic                 wr_cmd;
    logic                 rd_cmd;

    assign op           = opcode_t'(bus.din[9:8]);
    assign payload_addr = bus.din[ADDR_SIZE-1:0];
    assign wr_cmd       = bus.rx_valid && (op == OP_WR_DATA);
    assign rd_cmd       = bus.rx_valid && (op == OP_RD_DATA);

    // Storage array: written on opcode 01, intentionally never reset.
    always_ff @(posedge clk) begin
        if (wr_cmd) begin
            mem[wr_addr] <= bus.din[7:0];
        end
    end

    // Address latches: explicit 00/10 load, optional post-increment on 01/11.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr <= '0;
            rd_addr <= '0;
        end else if (bus.rx_valid) begin
            case (op)
                OP_WR_ADDR: wr_addr <= payload_addr;
                OP_RD_ADDR: rd_addr <= payload_addr;
`ifdef SPI_RAM_AUTO_INC_EN
                OP_WR_DATA: wr_addr <= wr_addr + 1'b1;
                OP_RD_DATA: rd_addr <= rd_addr + 1'b1;
`endif
                default: ;
            endcase
        end
    end

    // Read/transmit FSM: a read loads dout and (re)starts the TX_HOLD window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            dout_r     <= '0;
            tx_valid_r <= 1'b0;
        end else if (rd_cmd) begin
            // A read is honoured from either state, so a read during TX reloads.
            dout_r     <= mem[rd_addr];
            hold_cnt   <= HOLD_LOAD;
            state      <= TX;
            tx_valid_r <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    tx_valid_r <= 1'b0;
                end
                TX: begin
                    if (hold_cnt == '0) begin
                        state      <= IDLE;
                        tx_valid_r <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    tx_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout     = dout_r;
    assign bus.tx_valid = tx_valid_r;

endmodule
